// File: rtl/chest_interp_pkg.sv
// Shared types and helpers for the sequential channel-estimate interpolator.
// Holds the FSM state encoding, the accumulator width rule and the output
// shift (round-half-up when CHEST_INTERP_ROUND_EN is defined, floor otherwise).
package chest_interp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Accumulator must hold e_a<<LOG2_STEPS plus one step of full-scale D.
  function automatic int acc_w(input int width, input int log2_steps);
    return width + log2_steps + 2;
  endfunction

  // Scales the accumulator back down to sample units. Both endpoints are
  // multiples of 2^log2_steps, so they come out exact in either mode.
  function automatic logic signed [63:0] interp_shift(input logic signed [63:0] acc,
                                                      input int                 log2_steps);
`ifdef CHEST_INTERP_ROUND_EN
    logic signed [63:0] half;
    half = 64'sd1 <<< (log2_steps - 1);
    return (acc + half) >>> log2_steps;
`else
    return acc >>> log2_steps;
`endif
  endfunction

endpackage

// File: rtl/chest_interp_lane.sv
// One interpolation lane: endpoint registers, step D, accumulator, output shift.
// Ports: CLK/RST; load captures e_a/e_b, prep derives D and seeds acc,
// step adds D to acc; sample is the current interpolated value.
// Output rounding follows CHEST_INTERP_ROUND_EN (see chest_interp_pkg).
module chest_interp_lane
  import chest_interp_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int LOG2_STEPS = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             prep,
  input  logic             step,
  input  logic [WIDTH-1:0] e_a,
  input  logic [WIDTH-1:0] e_b,
  output logic [WIDTH-1:0] sample
);

  localparam int AW = acc_w(WIDTH, LOG2_STEPS);

  logic signed [WIDTH-1:0] ea_q;
  logic signed [WIDTH-1:0] eb_q;
  logic signed [WIDTH:0]   d_q;
  logic signed [AW-1:0]    acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ea_q <= '0;
      eb_q <= '0;
      d_q  <= '0;
      acc  <= '0;
    end else begin
      if (load) begin
        ea_q <= e_a;
        eb_q <= e_b;
      end
      if (prep) begin
        // One extra bit so a full-scale swing cannot wrap.
        d_q <= (WIDTH+1)'(eb_q) - (WIDTH+1)'(ea_q);
        acc <= AW'(ea_q) <<< LOG2_STEPS;
      end else if (step) begin
        acc <= acc + AW'(d_q);
      end
    end
  end

  // Every sample lies between e_a and e_b, so narrowing back to WIDTH is safe.
  assign sample = WIDTH'(interp_shift(64'(acc), LOG2_STEPS));

endmodule

// File: rtl/chest_interp_seq.sv
// Sequential linear interpolator: emits 2^LOG2_STEPS+1 samples from E_a to E_b per lane.
// Ports: CLK, RST (async, active-high), in_valid/in_ready/e_a/e_b request side,
// out_valid/out_ready/out_data/out_last sample side, busy while PREP or RUN.
// Latency: request accepted on one edge, first sample valid after the following edge.
// Backpressure: out_ready low holds out_data/out_last; in_ready low while busy.
// Optional macro CHEST_INTERP_ROUND_EN selects round-half-up instead of floor.
module chest_interp_seq
  import chest_interp_pkg::*;
#(
  parameter int WIDTH      = 17,
  parameter int LANES      = 2,
  parameter int LOG2_STEPS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] e_a,
  input  logic [LANES*WIDTH-1:0] e_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic [LOG2_STEPS:0] K_LAST = (LOG2_STEPS+1)'(1 << LOG2_STEPS);
  localparam logic [LOG2_STEPS:0] K_ONE  = (LOG2_STEPS+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [LOG2_STEPS:0] k;
  logic                load;
  logic                prep;
  logic                step;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    prep      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = PREP;
        end
      end
      PREP: begin
        busy      = 1'b1;
        prep      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (k == K_LAST);
        if (out_ready) begin
          // The final accept leaves acc on e_b instead of stepping past it.
          if (out_last) state_nxt = IDLE;
          else          step      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       k <= '0;
    else if (prep) k <= '0;
    else if (step) k <= k + K_ONE;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    chest_interp_lane #(
      .WIDTH      (WIDTH),
      .LOG2_STEPS (LOG2_STEPS)
    ) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .load   (load),
      .prep   (prep),
      .step   (step),
      .e_a    (e_a[i*WIDTH +: WIDTH]),
      .e_b    (e_b[i*WIDTH +: WIDTH]),
      .sample (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_chest_interp_seq.sv
module tb_chest_interp_seq;
  localparam int W     = 17;
  localparam int LN    = 2;
  localparam int L2    = 2;
  localparam int STEPS = 1 << L2;
  localparam int NV    = 5;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LN*W-1:0] e_a = '0;
  logic [LN*W-1:0] e_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LN*W-1:0] out_data;
  logic            out_last;
  logic            busy;

  int tests = 0;
  int fails = 0;

  chest_interp_seq #(.WIDTH(W), .LANES(LN), .LOG2_STEPS(L2)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .e_a(e_a), .e_b(e_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    a0, b0, a1, b1;
    int    stall_at, stall_len;
    bit    poke;
    string nm;
  } vec_t;

  vec_t vt[NV];
  int   xt[NV][2][STEPS+1];

  // Ideal line y = ea + k*(eb-ea)/STEPS, then floor or round-half-up.
  function automatic int model(input int ea, input int eb, input int k);
    real y;
    y = real'(ea) + real'(k) * real'(eb - ea) / real'(STEPS);
`ifdef CHEST_INTERP_ROUND_EN
    return int'($floor(y + 0.5));
`else
    return int'($floor(y));
`endif
  endfunction

  function automatic int lane_val(input int l);
    logic signed [W-1:0] v;
    v = out_data[l*W +: W];
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Leaves in_valid high at a negedge where in_ready is high.
  task automatic send(input int a0, input int b0, input int a1, input int b1);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("send_in_ready", int'(in_ready), 1);
    e_a      = {W'(a1), W'(a0)};
    e_b      = {W'(b1), W'(b0)};
    in_valid = 1'b1;
  endtask

  task automatic run_check(input int a0, input int b0, input int a1, input int b1,
                           input int x0[STEPS+1], input int x1[STEPS+1],
                           input int stall_at, input int stall_len,
                           input bit poke, input string nm);
    int idx   = 0;
    int stall = 0;
    int cyc   = 0;
    send(a0, b0, a1, b1);
    while (idx <= STEPS && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      in_valid = poke && out_valid;
      if (poke) begin
        e_a = {W'($urandom), W'($urandom)};
        e_b = {W'($urandom), W'($urandom)};
      end
      if (!out_valid) begin
        out_ready = 1'b1;
      end else begin
        chk({nm, "_lane0"}, lane_val(0), x0[idx]);
        chk({nm, "_lane1"}, lane_val(1), x1[idx]);
        chk({nm, "_last"}, int'(out_last), int'(idx == STEPS));
        if (idx == stall_at && stall < stall_len) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          idx++;
        end
      end
    end
    chk({nm, "_complete"}, idx, STEPS + 1);
    @(negedge CLK);
    in_valid = 1'b0;
    chk({nm, "_idle_after"}, int'(in_ready), 1);
    chk({nm, "_no_extra"}, int'(out_valid), 0);
  endtask

  initial begin
    int x0[STEPS+1];
    int x1[STEPS+1];
    int n;

    vt[0] = '{0, 8, 8, 0, -1, 0, 1'b0, "ramp"};
    vt[1] = '{5, -3, -4, 4, 2, 3, 1'b1, "neg_bp"};
    vt[2] = '{0, 3, 0, -3, -1, 0, 1'b0, "round"};
    vt[3] = '{-65536, 65535, 65535, -65536, -1, 0, 1'b0, "extreme"};
    vt[4] = '{1234, 1234, -7, -7, 1, 2, 1'b0, "const"};
    xt[0] = '{'{0, 2, 4, 6, 8}, '{8, 6, 4, 2, 0}};
    xt[1] = '{'{5, 3, 1, -1, -3}, '{-4, -2, 0, 2, 4}};
    xt[4] = '{'{1234, 1234, 1234, 1234, 1234}, '{-7, -7, -7, -7, -7}};
`ifdef CHEST_INTERP_ROUND_EN
    xt[2] = '{'{0, 1, 2, 2, 3}, '{0, -1, -1, -2, -3}};
    xt[3] = '{'{-65536, -32768, 0, 32767, 65535}, '{65535, 32767, 0, -32768, -65536}};
`else
    xt[2] = '{'{0, 0, 1, 2, 3}, '{0, -1, -2, -3, -3}};
    xt[3] = '{'{-65536, -32769, -1, 32767, 65535}, '{65535, 32767, -1, -32769, -65536}};
`endif

    // Reset state
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Latency and back-to-back throughput on a 0..8 ramp
    out_ready = 1'b1;
    send(0, 8, 0, 8);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("lat_prep_valid", int'(out_valid), 0);
    chk("lat_prep_busy", int'(busy), 1);
    chk("lat_prep_in_ready", int'(in_ready), 0);
    for (int k = 0; k <= STEPS; k++) begin
      @(negedge CLK);
      chk("ramp_valid", int'(out_valid), 1);
      chk("ramp_data", lane_val(0), 2 * k);
      chk("ramp_last", int'(out_last), int'(k == STEPS));
    end
    @(negedge CLK);
    chk("ramp_back_idle", int'(in_ready), 1);

    // Table-driven vectors
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k <= STEPS; k++) begin
        x0[k] = xt[v][0][k];
        x1[k] = xt[v][1][k];
      end
      run_check(vt[v].a0, vt[v].b0, vt[v].a1, vt[v].b1, x0, x1,
                vt[v].stall_at, vt[v].stall_len, vt[v].poke, vt[v].nm);
    end

    // Reset in the middle of a run
    out_ready = 1'b1;
    send(0, 8, 0, -8);
    n = 0;
    @(negedge CLK);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("mid_first", lane_val(0), 0);
    @(negedge CLK);
    chk("mid_k1", lane_val(0), 2);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_last", int'(out_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k <= STEPS; k++) begin
      x0[k] = model(0, 8, k);
      x1[k] = model(0, -8, k);
    end
    run_check(0, 8, 0, -8, x0, x1, -1, 0, 1'b0, "post_rst");

    // Random requests with random stalls against the line model
    for (int r = 0; r < 20; r++) begin
      int a0, b0, a1, b1;
      a0 = int'($urandom_range(131071)) - 65536;
      b0 = int'($urandom_range(131071)) - 65536;
      a1 = int'($urandom_range(131071)) - 65536;
      b1 = int'($urandom_range(131071)) - 65536;
      for (int k = 0; k <= STEPS; k++) begin
        x0[k] = model(a0, b0, k);
        x1[k] = model(a1, b1, k);
      end
      run_check(a0, b0, a1, b1, x0, x1, int'($urandom_range(STEPS)),
                int'($urandom_range(3)), 1'($urandom_range(1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
